// File: rtl/day04_tt_pkg.sv
// day04_tt_pkg: pin bit map, host state encoding and result byte assembly for the Day 4 TinyTapeout host
package day04_tt_pkg;
    localparam int PART2 = 0, IN_VALID = 1, START = 2, READ_NEXT = 3;
    localparam int IN_READY = 0, OUT_VALID = 1;
    typedef enum logic [2:0] {S_IDLE, S_RST, S_FEED, S_START, S_WAIT, S_SETTLE, S_READ, S_DONE} state_t;
    function automatic logic [7:0] tt_byte(input logic [5:0] uo_hi, input logic [1:0] uio_lo);
        return {uio_lo, uo_hi};
    endfunction
endpackage

// File: rtl/day04_tt_watchdog.sv
// day04_tt_watchdog: clearable enabled counter that saturates and flags expiry after TIMEOUT_CYCLES counts
module day04_tt_watchdog #(
    parameter int TIMEOUT_CYCLES = 1 << 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt;
    assign expired = cnt == W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + W'(1);
endmodule

// File: rtl/day04_tt_host.sv
// day04_tt_host: resets the chip, streams puzzle chars into its pins, starts it, waits with a watchdog
// and reads the 32-bit count back byte by byte, least significant byte first.
module day04_tt_host
    import day04_tt_pkg::*;
#(
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1 << 24
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        go,
    input  logic        part2,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    input  logic        char_last,
    output logic        char_ready,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        timeout,
    output logic        busy,
    output logic [7:0]  pin_ui_in,
    output logic [7:0]  pin_uio_in,
    output logic        pin_rst_n,
    input  logic [7:0]  pin_uo_out,
    input  logic [7:0]  pin_uio_out
);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    state_t        state;
    logic [RW-1:0] rcnt;
    logic [1:0]    k;
    logic          last_q, ph, expired, unused;

    assign busy       = state != S_IDLE;
    assign char_ready = state == S_FEED && pin_uo_out[IN_READY] && !pin_uio_in[IN_VALID];
    assign unused     = ^pin_uio_out[7:2];

    day04_tt_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk(clock),
        .rst(clear),
        .clr(state == S_START),
        .en(state == S_WAIT || state == S_SETTLE),
        .expired(expired)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state        <= S_IDLE;
            rcnt         <= '0;
            k            <= '0;
            last_q       <= 1'b0;
            ph           <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            pin_ui_in    <= '0;
            pin_uio_in   <= '0;
            pin_rst_n    <= 1'b1;
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_IDLE: if (go) begin
                    pin_uio_in[PART2] <= part2;
                    timeout           <= 1'b0;
                    pin_rst_n         <= 1'b0;
                    rcnt              <= '0;
                    state             <= S_RST;
                end
                S_RST: if (rcnt == RW'(RESET_CYCLES - 1)) begin
                    pin_rst_n <= 1'b1;
                    state     <= S_FEED;
                end else rcnt <= rcnt + RW'(1);
                // the in_valid pin doubles as the strobe-pending flag
                S_FEED: if (pin_uio_in[IN_VALID]) begin
                    pin_uio_in[IN_VALID] <= 1'b0;
                    if (last_q) begin
                        pin_uio_in[START] <= 1'b1;
                        state             <= S_START;
                    end
                end else if (char_ready && char_valid) begin
                    pin_ui_in            <= char_data;
                    pin_uio_in[IN_VALID] <= 1'b1;
                    last_q               <= char_last;
                end
                S_START: begin
                    pin_uio_in[START] <= 1'b0;
                    state             <= S_WAIT;
                end
                S_WAIT, S_SETTLE: if (expired) begin
                    timeout    <= 1'b1;
                    pin_uio_in <= '0;
                    state      <= S_IDLE;
                end else if (state == S_WAIT && pin_uo_out[OUT_VALID]) state <= S_SETTLE;
                else if (state == S_SETTLE && !pin_uo_out[OUT_VALID]) begin
                    k     <= '0;
                    ph    <= 1'b0;
                    state <= S_READ;
                end
                S_READ: if (!ph) begin
                    result[{k, 3'b000} +: 8] <= tt_byte(pin_uo_out[7:2], pin_uio_out[1:0]);
                    if (k == 2'd3) begin
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        pin_uio_in[READ_NEXT] <= 1'b1;
                        ph                    <= 1'b1;
                    end
                end else begin
                    pin_uio_in[READ_NEXT] <= 1'b0;
                    ph                    <= 1'b0;
                    k                     <= k + 2'd1;
                end
                S_DONE: begin
                    pin_uio_in[PART2] <= 1'b0;
                    state             <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_day04_tt_host.sv
// tb_day04_tt_host: scoreboard bench for day04_tt_host driven against a cycle-level model of the chip pins
module tb_day04_tt_host;
    logic        clock = 0, clear = 1, go = 0, part2 = 0;
    logic [7:0]  char_data = 0;
    logic        char_valid = 0, char_last = 0;
    logic        char_ready, result_valid, timeout, busy, pin_rst_n;
    logic [31:0] result;
    logic [7:0]  pin_ui_in, pin_uio_in, pin_uo_out, pin_uio_out;

    int n_checks = 0, n_fail = 0;
    int n_strobe = 0, n_start = 0, n_rn = 0, n_rv = 0;
    int cyc = 0, last_iv = -10, nf = -100;
    logic prev_ov = 0, exp_p2 = 0;
    logic [7:0]  cq[$];
    logic [31:0] rq[$];
    logic [7:0]  exp8;
    logic [31:0] exp32;

    logic        ir_en = 1, hang = 0, ov = 0;
    logic [31:0] chip_val = 0, sr = 0;
    int          ch_st = 0, ch_cnt = 0;

    always #5 clock = ~clock;

    day04_tt_host #(.RESET_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .clock(clock), .clear(clear), .go(go), .part2(part2),
        .char_data(char_data), .char_valid(char_valid), .char_last(char_last),
        .char_ready(char_ready), .result(result), .result_valid(result_valid),
        .timeout(timeout), .busy(busy), .pin_ui_in(pin_ui_in), .pin_uio_in(pin_uio_in),
        .pin_rst_n(pin_rst_n), .pin_uo_out(pin_uo_out), .pin_uio_out(pin_uio_out)
    );

    // chip model: delay after start, out_valid high 3 cycles while loading, then shift out on read_next
    assign pin_uo_out  = {sr[5:0], ov, ir_en & pin_rst_n};
    assign pin_uio_out = {6'b0, sr[7:6]};
    always @(posedge clock) begin
        if (!pin_rst_n) begin
            ch_st <= 0; ch_cnt <= 0; ov <= 0; sr <= 0;
        end else case (ch_st)
            0: if (pin_uio_in[2]) begin ch_st <= 1; ch_cnt <= 0; end
            1: if (!hang) begin
                if (ch_cnt == 4) begin ov <= 1; sr <= chip_val; ch_cnt <= 0; ch_st <= 2; end
                else ch_cnt <= ch_cnt + 1;
            end
            2: if (ch_cnt == 2) begin ov <= 0; ch_st <= 3; end else ch_cnt <= ch_cnt + 1;
            default: if (pin_uio_in[3]) sr <= sr >> 8;
        endcase
    end

    always @(negedge clock) begin
        cyc++;
        if (!clear) begin
            if (busy) begin
                n_checks++;
                if (pin_uio_in[0] !== exp_p2) begin n_fail++; $display("FAIL part2_pin: got %0b want %0b", pin_uio_in[0], exp_p2); end
            end
            if (pin_uio_in[1]) begin
                n_strobe++;
                n_checks++;
                if (cq.size() == 0) begin n_fail++; $display("FAIL strobe_unexpected: got 0x%02h want none", pin_ui_in); end
                else begin
                    exp8 = cq.pop_front();
                    if (pin_ui_in !== exp8) begin n_fail++; $display("FAIL strobe_char: got 0x%02h want 0x%02h", pin_ui_in, exp8); end
                end
                n_checks++;
                if (cyc - last_iv < 2) begin n_fail++; $display("FAIL strobe_spacing: got %0d want >=2", cyc - last_iv); end
                last_iv = cyc;
            end
            if (pin_uio_in[2]) begin
                n_start++;
                n_checks++;
                if (cyc != last_iv + 1) begin n_fail++; $display("FAIL start_delay: got %0d want 1", cyc - last_iv); end
            end
            if (pin_uio_in[3]) begin
                n_rn++;
                n_checks++;
                if (pin_uo_out[1]) begin n_fail++; $display("FAIL read_next_early: got out_valid=1 want 0"); end
            end
            if (prev_ov && !pin_uo_out[1]) nf = cyc;
            if (result_valid) begin
                n_rv++;
                n_checks++;
                if (rq.size() == 0) begin n_fail++; $display("FAIL result_unexpected: got 0x%08h want none", result); end
                else begin
                    exp32 = rq.pop_front();
                    if (result !== exp32) begin n_fail++; $display("FAIL result_value: got 0x%08h want 0x%08h", result, exp32); end
                end
                n_checks++;
                if (cyc - nf != 8) begin n_fail++; $display("FAIL result_latency: got %0d want 8", cyc - nf); end
            end
        end
        prev_ov = pin_uo_out[1];
    end

    task automatic start_run(input logic p2, input logic [31:0] val, input logic expect_result);
        chip_val = val; exp_p2 = p2;
        n_strobe = 0; n_start = 0; n_rn = 0; n_rv = 0;
        if (expect_result) rq.push_back(val);
        @(negedge clock); go = 1; part2 = p2;
        @(negedge clock); go = 0; part2 = 0;
    endtask

    task automatic wait_feed(output int lo);
        lo = 0;
        while (!pin_rst_n && lo < 50) begin @(negedge clock); lo++; end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        char_data = b; char_valid = 1; char_last = last;
        while (char_ready !== 1 && n < 200) begin @(negedge clock); n++; end
        n_checks++;
        if (n >= 200) begin n_fail++; $display("FAIL char_accept: got no char_ready want accept within 200"); end
        else cq.push_back(b);
        @(negedge clock); char_valid = 0; char_last = 0;
    endtask

    task automatic finish_run(input logic [31:0] val, input int nchars);
        int n = 0;
        while (result_valid !== 1 && n < 500) begin @(negedge clock); n++; end
        n_checks++;
        if (n >= 500) begin n_fail++; $display("FAIL result_wait: got no result_valid want pulse within 500"); end
        @(negedge clock);
        n_checks++;
        if (result_valid !== 0 || busy !== 0) begin n_fail++; $display("FAIL done_pulse: got rv=%0b busy=%0b want 0 0", result_valid, busy); end
        n_checks++;
        if (result !== val) begin n_fail++; $display("FAIL result_hold: got 0x%08h want 0x%08h", result, val); end
        n_checks++;
        if (n_rn != 3 || n_start != 1 || n_strobe != nchars) begin
            n_fail++; $display("FAIL pulse_counts: got rn=%0d start=%0d strobe=%0d want 3 1 %0d", n_rn, n_start, n_strobe, nchars);
        end
        n_checks++;
        if (rq.size() != 0 || cq.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d/%0d want 0/0", rq.size(), cq.size()); end
    endtask

    task automatic test_reset();
        clear = 1; go = 1;
        repeat (3) begin
            @(negedge clock);
            n_checks++;
            if (pin_rst_n !== 1 || pin_uio_in !== 8'h00 || pin_ui_in !== 8'h00 || busy !== 0 || result !== 0 ||
                char_ready !== 0 || result_valid !== 0 || timeout !== 0) begin
                n_fail++; $display("FAIL reset_values: got rst_n=%0b uio=0x%02h busy=%0b result=0x%08h want 1 0x00 0 0", pin_rst_n, pin_uio_in, busy, result);
            end
        end
        clear = 0; go = 0;
        @(negedge clock);
        n_checks++;
        if (busy !== 0 || pin_rst_n !== 1) begin n_fail++; $display("FAIL reset_release: got busy=%0b rst_n=%0b want 0 1", busy, pin_rst_n); end
    endtask

    task automatic test_main();
        int lo;
        start_run(1, 32'h12345678, 1);
        wait_feed(lo);
        n_checks++;
        if (lo != 4) begin n_fail++; $display("FAIL rst_low_cycles: got %0d want 4", lo); end
        send(8'h40, 0); send(8'h2E, 0); send(8'h40, 0); send(8'h0A, 1);
        finish_run(32'h12345678, 4);
    endtask

    task automatic test_backpressure();
        int lo;
        ir_en = 0;
        start_run(0, 32'hA5C30F81, 1);
        wait_feed(lo);
        char_data = 8'h23; char_valid = 1; char_last = 0;
        repeat (10) begin
            n_checks++;
            if (char_ready !== 0) begin n_fail++; $display("FAIL ready_while_blocked: got %0b want 0", char_ready); end
            @(negedge clock);
        end
        n_checks++;
        if (n_strobe != 0) begin n_fail++; $display("FAIL strobe_while_blocked: got %0d want 0", n_strobe); end
        ir_en = 1;
        #1;
        n_checks++;
        if (char_ready !== 1) begin n_fail++; $display("FAIL ready_on_return: got %0b want 1", char_ready); end
        send(8'h23, 0); send(8'h0A, 1);
        finish_run(32'hA5C30F81, 2);
    endtask

    task automatic test_back_to_back();
        int lo, len;
        logic [31:0] v;
        for (int r = 0; r < 3; r++) begin
            v = $urandom;
            len = $urandom_range(1, 5);
            start_run(r[0], v, 1);
            wait_feed(lo);
            for (int i = 0; i < len; i++) begin
                send(8'($urandom_range(32, 126)), i == len - 1);
                if (i == 0 && len > 1) begin
                    go = 1;
                    @(negedge clock); go = 0;
                    n_checks++;
                    if (pin_rst_n !== 1 || busy !== 1) begin n_fail++; $display("FAIL go_ignored: got rst_n=%0b busy=%0b want 1 1", pin_rst_n, busy); end
                end
            end
            finish_run(v, len);
        end
    endtask

    task automatic test_timeout();
        int lo, m = 0;
        logic [31:0] prev;
        prev = result;
        hang = 1;
        start_run(0, 32'h0, 0);
        wait_feed(lo);
        send(8'h0A, 1);
        while (pin_uio_in[2] !== 1 && m < 20) begin @(negedge clock); m++; end
        m = 0;
        while (busy && m < 300) begin @(negedge clock); m++; end
        n_checks++;
        if (m != 101) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 101", m); end
        n_checks++;
        if (timeout !== 1 || busy !== 0 || result !== prev || n_rv != 0) begin
            n_fail++; $display("FAIL timeout_state: got to=%0b busy=%0b result=0x%08h rv=%0d want 1 0 0x%08h 0", timeout, busy, result, n_rv, prev);
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if (timeout !== 1) begin n_fail++; $display("FAIL timeout_sticky: got %0b want 1", timeout); end
        hang = 0;
        start_run(1, 32'h0BADF00D, 1);
        n_checks++;
        if (timeout !== 0) begin n_fail++; $display("FAIL timeout_clear: got %0b want 0", timeout); end
        wait_feed(lo);
        send(8'h2E, 1);
        finish_run(32'h0BADF00D, 1);
    endtask

    task automatic test_clear_midrun();
        int lo;
        start_run(0, 32'h11111111, 0);
        wait_feed(lo);
        send(8'h40, 0);
        #2 clear = 1;
        #1;
        n_checks++;
        if (pin_rst_n !== 1 || busy !== 0 || pin_uio_in !== 8'h00 || result !== 0) begin
            n_fail++; $display("FAIL clear_midrun: got rst_n=%0b busy=%0b uio=0x%02h result=0x%08h want 1 0 0x00 0", pin_rst_n, busy, pin_uio_in, result);
        end
        @(negedge clock); clear = 0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (busy !== 0 || n_rv != 0 || cq.size() != 0) begin n_fail++; $display("FAIL clear_idle: got busy=%0b rv=%0d q=%0d want 0 0 0", busy, n_rv, cq.size()); end
    endtask

    initial begin
        test_reset();
        test_main();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_clear_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no completion want finish within 1ms");
        $fatal(1);
    end
endmodule
